err_stream_driver: RTL and testbench
====================================

// Module: err_stream_driver
// PURPOSE
//   Initiator for the squared-error collector. On a host command it reads SEQ_LEN
//   {ref,in} sample pairs from a 1-cycle-latency sample RAM and streams them with
//   the collector's alignment. It pulses the collector start, then captures the
//   64-bit error result and holds it for the host under valid/ready.
// PARAMETERS
//   SEQ_LEN   131072  sample pairs per run; must equal the collector's SEQ_LEN
//   ADDR_W    17      sample RAM address width; 2**ADDR_W >= SEQ_LEN
//   TIMEOUT   64      cycles allowed after coll_start+SEQ_LEN+2 for coll_valid
// PORTS
//   clk        in   1       clock
//   rstn       in   1       reset, synchronous, active-low
//   cmd_start  in   1       host run request (single-cycle pulse)
//   busy       out  1       high in any state other than IDLE
//   mem_en     out  1       sample RAM read enable
//   mem_addr   out  ADDR_W  sample RAM read address
//   mem_rdata  in   58      {ref[57:29], in[28:0]}, valid 1 cycle after mem_en
//   tx_in      out  29      sample to collector data_in
//   tx_ref     out  29      sample to collector data_ref
//   coll_start out  1       one-cycle start pulse to collector
//   coll_data  in   64      collector result
//   coll_valid in   1       collector result strobe (one cycle)
//   res_data   out  64      captured result
//   res_valid  out  1       result available; held until res_ready
//   res_ready  in   1       host accepts result
//   res_err    out  1       high with res_valid when the run timed out
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts
//     immediately. No result is produced. Samples already in flight are discarded.
//   FSM: IDLE -> STREAM -> DRAIN -> WAIT_RES -> HOLD -> IDLE.
//   IDLE: cmd_start=1 -> STREAM next cycle. cmd_start is ignored in all other states.
//   STREAM: mem_en=1 and mem_addr = 0,1,..,SEQ_LEN-1 on consecutive cycles (A+k).
//     After address SEQ_LEN-1 -> DRAIN. There are no gaps and no stalls.
//   Data path: tx_in/tx_ref are registered from mem_rdata. Sample k appears on
//     tx_* at cycle T0+k, with T0=A+2. tx_* are 0 outside T0..T0+SEQ_LEN-1.
//   coll_start=1 for exactly one cycle, at T0+1; this is the collector's
//     alignment contract (first pair one cycle before start).
//   DRAIN: wait until the last sample has left tx_*, then -> WAIT_RES.
//   WAIT_RES: on coll_valid, capture res_data<=coll_data, set res_valid=1 and
//     res_err=0, go to HOLD.
//     - A 32-bit watchdog starts at coll_start.
//     - If it reaches SEQ_LEN+2+TIMEOUT without coll_valid: res_data=0,
//       res_valid=1, res_err=1, go to HOLD.
//   coll_valid outside WAIT_RES is ignored (no capture, no error).
//   HOLD: res_valid, res_data and res_err are stable while res_ready=0.
//     When res_valid&&res_ready, clear res_valid/res_err next cycle -> IDLE.
//     res_data keeps its last value.
//   busy=0 only in IDLE. cmd_start in the same cycle as the HOLD handshake
//     is ignored; the host re-issues it once busy=0.
//   Widths: mem_addr counter is ADDR_W bits and must not wrap within a run.
//     Sample fields are passed bit-exact, with no sign handling.
// TESTING
//   1 SEQ_LEN=8, in=k, ref=k+1024, collector RTL attached ->
//     coll_start once at T0+1, res_data=1024 (8*2^20>>13), res_err=0.
//   2 Alignment: check tx_in=k at T0+k for k=0..7, coll_start one cycle only,
//     tx_*=0 at T0-1 and T0+8, mem_addr 0..7 contiguous.
//   3 Collector stubbed, never asserts coll_valid -> res_valid=1, res_err=1,
//     res_data=0 exactly SEQ_LEN+2+TIMEOUT cycles after coll_start.
//   4 res_ready held 0 for 20 cycles -> res_* stable, busy=1, a cmd_start
//     pulse is ignored. res_ready=1 -> IDLE next cycle, a new run works.
//   5 rstn=0 at mid-STREAM (k=4) -> all outputs 0 next cycle, no res_valid.
//     A fresh cmd_start gives a correct result.
//   6 Back-to-back runs with cmd_start pulsed while busy -> exactly one
//     coll_start per accepted command, and results match the model.

Source files
------------

// File: rtl/err_stream_driver.sv
// err_stream_driver: host-commanded initiator for the squared-error collector.
// Reads SEQ_LEN {ref,in} pairs from a 1-cycle-latency sample RAM and streams
// them to the collector. The first pair leads coll_start by one cycle. The
// 64-bit result, or a timeout flag, is then held for the host.
//
// Handshake: o_res_valid rises with a result and stays high, with o_res_data
// and o_res_err unchanged, until a cycle where i_res_ready is also high. It
// drops on the next cycle.
module err_stream_driver #(
  parameter int SEQ_LEN = 131072,
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_cmd_start,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [57:0]       i_mem_rdata,
  output logic [28:0]       o_tx_in,
  output logic [28:0]       o_tx_ref,
  output logic              o_coll_start,
  input  logic [63:0]       i_coll_data,
  input  logic              i_coll_valid,
  output logic [63:0]       o_res_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_err,
  output logic [2:0]        o_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] STREAM   = 3'd1;
  localparam logic [2:0] DRAIN    = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_LEN - 1);
  // The watchdog reads WD_LIMIT-1 one cycle before the timeout becomes visible.
  localparam logic [31:0]       WD_LIMIT  = 32'(SEQ_LEN + 2 + TIMEOUT);

  logic [2:0]        r_state;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_vld;
  logic              r_tx_vld;
  logic              r_first1;
  logic              r_first2;
  logic              r_coll_start;
  logic [28:0]       r_tx_in;
  logic [28:0]       r_tx_ref;
  logic [31:0]       r_wd;
  logic              r_wd_run;
  logic [63:0]       r_res_data;
  logic              r_res_valid;
  logic              r_res_err;
  logic              w_wd_expired;

  assign w_wd_expired = r_wd_run && (r_wd == WD_LIMIT - 32'd1);

  // Read pipeline: RAM data lands one cycle after mem_en and is registered
  // onto tx_*. Address 0 is tracked down the pipe so that coll_start fires
  // one cycle after sample 0 reaches tx_*.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_vld     <= 1'b0;
      r_tx_vld     <= 1'b0;
      r_first1     <= 1'b0;
      r_first2     <= 1'b0;
      r_coll_start <= 1'b0;
      r_tx_in      <= '0;
      r_tx_ref     <= '0;
    end else begin
      r_rd_vld     <= r_mem_en;
      r_tx_vld     <= r_rd_vld;
      r_first1     <= r_mem_en && (r_mem_addr == '0);
      r_first2     <= r_first1;
      r_coll_start <= r_first2;
      r_tx_in      <= r_rd_vld ? i_mem_rdata[28:0]  : 29'd0;
      r_tx_ref     <= r_rd_vld ? i_mem_rdata[57:29] : 29'd0;
    end
  end

  // Watchdog: restarts on coll_start and runs until the result is taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wd     <= '0;
      r_wd_run <= 1'b0;
    end else if (r_coll_start) begin
      r_wd     <= 32'd1;
      r_wd_run <= 1'b1;
    end else if (r_state == IDLE || r_state == HOLD) begin
      r_wd     <= '0;
      r_wd_run <= 1'b0;
    end else if (r_wd_run) begin
      r_wd     <= r_wd + 32'd1;
    end
  end

  // Control FSM: address generation, drain, result capture and host hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_start) begin
            r_state    <= STREAM;
            r_mem_en   <= 1'b1;
            r_mem_addr <= '0;
          end
        end
        STREAM: begin
          if (r_mem_addr == LAST_ADDR) begin
            r_state    <= DRAIN;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_mem_addr <= r_mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last sample has left tx_* once both pipe stages are empty.
          if (!r_rd_vld && !r_tx_vld) r_state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (i_coll_valid) begin
            r_res_data  <= i_coll_data;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
            r_state     <= HOLD;
          end else if (w_wd_expired) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (r_res_valid && i_res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_mem_en     = r_mem_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_tx_in      = r_tx_in;
  assign o_tx_ref     = r_tx_ref;
  assign o_coll_start = r_coll_start;
  assign o_res_data   = r_res_data;
  assign o_res_valid  = r_res_valid;
  assign o_res_err    = r_res_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_err_stream_driver.sv
// Bench for err_stream_driver with SEQ_LEN=8. It provides a sample RAM model
// and a behavioural collector stub, and keeps a queue of expected
// {err,data} results.
module tb_err_stream_driver;

  localparam int SEQ_LEN = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;
  localparam int WD_N    = SEQ_LEN + 2 + TIMEOUT;

  logic              clk;
  logic              rstn;
  logic              i_cmd_start;
  logic              o_busy;
  logic              o_mem_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [57:0]       i_mem_rdata;
  logic [28:0]       o_tx_in;
  logic [28:0]       o_tx_ref;
  logic              o_coll_start;
  logic [63:0]       i_coll_data;
  logic              i_coll_valid;
  logic [63:0]       o_res_data;
  logic              o_res_valid;
  logic              i_res_ready;
  logic              o_res_err;
  logic [2:0]        o_state;

  logic [57:0] mem [16];
  logic [64:0] exp_q [$];
  int          n_chk;
  int          n_err;
  int          n_cs;

  logic        stub_en;
  logic        spur_req;
  logic [63:0] st_acc;
  int          st_cnt;
  int          st_dly;
  logic [28:0] st_prev_in;
  logic [28:0] st_prev_ref;

  err_stream_driver #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .i_cmd_start(i_cmd_start), .o_busy(o_busy),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
    .o_tx_in(o_tx_in), .o_tx_ref(o_tx_ref), .o_coll_start(o_coll_start),
    .i_coll_data(i_coll_data), .i_coll_valid(i_coll_valid),
    .o_res_data(o_res_data), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_res_err(o_res_err), .o_state(o_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sq(input logic [28:0] a, input logic [28:0] b);
    logic [63:0] d;
    d = (a > b) ? 64'(a - b) : 64'(b - a);
    return d * d;
  endfunction

  function automatic logic [63:0] model();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < SEQ_LEN; k++) s = s + sq(mem[k][57:29], mem[k][28:0]);
    return s >> 13;
  endfunction

  // Sample RAM with one cycle of read latency
  always @(posedge clk) if (o_mem_en) i_mem_rdata <= mem[o_mem_addr];

  // Collector stub: the pair on tx_* in the cycle before coll_start is pair 0
  always @(posedge clk) begin
    st_prev_in   <= o_tx_in;
    st_prev_ref  <= o_tx_ref;
    i_coll_valid <= spur_req;
    if (spur_req) i_coll_data <= 64'hDEAD_BEEF;
    if (!rstn) begin
      st_cnt <= 0;
      st_acc <= '0;
    end else if (stub_en && o_coll_start) begin
      st_acc <= sq(st_prev_ref, st_prev_in) + sq(o_tx_ref, o_tx_in);
      st_cnt <= 2;
    end else if (st_cnt > 0 && st_cnt < SEQ_LEN) begin
      st_acc <= st_acc + sq(o_tx_ref, o_tx_in);
      st_cnt <= st_cnt + 1;
    end else if (st_cnt == SEQ_LEN) begin
      st_cnt <= SEQ_LEN + 1;
      st_dly <= 3;
    end else if (st_cnt == SEQ_LEN + 1) begin
      if (st_dly == 0) begin
        i_coll_valid <= 1'b1;
        i_coll_data  <= st_acc >> 13;
        st_cnt       <= 0;
      end else begin
        st_dly <= st_dly - 1;
      end
    end
  end

  // Count coll_start pulses seen on the wire
  always @(negedge clk) if (rstn && o_coll_start) n_cs++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pattern(input int p);
    for (int k = 0; k < SEQ_LEN; k++) begin
      case (p)
        0:       mem[k] = {29'(k + 1024), 29'(k)};
        1:       mem[k] = {29'($urandom_range(0, 32'h1FFF_FFFF)), 29'($urandom_range(0, 32'h1FFF_FFFF))};
        2:       mem[k] = {29'h1FFF_FFFF, 29'(k * 3)};
        default: mem[k] = {29'($urandom_range(0, 4095)), 29'($urandom_range(0, 4095))};
      endcase
    end
  endtask

  // Driver: load RAM, optionally queue the expected result, pulse cmd_start.
  task automatic start_run(input int p, input bit push);
    load_pattern(p);
    if (push) exp_q.push_back(stub_en ? {1'b0, model()} : {1'b1, 64'd0});
    i_cmd_start = 1'b1;
    tick();
    i_cmd_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_res_valid && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 65'(o_res_valid), 65'(1));
  endtask

  // Scoreboard pop and host handshake
  task automatic accept(input string tag);
    logic [64:0] e;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
    chk(tag, {o_res_err, o_res_data}, e);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk({tag, "_release"}, {63'd0, o_res_valid, o_busy}, 65'd0);
  endtask

  initial begin
    logic [64:0] held;
    bit          stable;
    int          cs0;
    int          n;
    n_chk = 0; n_err = 0; n_cs = 0;
    rstn = 1'b0; i_cmd_start = 1'b0; i_res_ready = 1'b0;
    stub_en = 1'b1; spur_req = 1'b0; i_coll_valid = 1'b0; i_coll_data = '0;
    i_mem_rdata = '0; st_cnt = 0; st_dly = 0; st_acc = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) tick();
    chk("reset_outputs", {o_busy, o_mem_en, o_mem_addr, o_tx_in, o_tx_ref, o_coll_start,
                          o_res_valid, o_res_err, o_state},
        65'd0);
    chk("reset_res_data", {1'b0, o_res_data}, 65'd0);
    rstn = 1'b1;
    tick();

    // Spurious coll_valid while idle is ignored
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    repeat (2) tick();
    chk("idle_coll_valid", {62'd0, o_res_valid, o_busy, o_res_err}, 65'd0);

    // Basic run with cycle-by-cycle alignment; j=0 is the first STREAM cycle
    cs0 = n_cs;
    start_run(0, 1);
    for (int j = 0; j <= 10; j++) begin
      chk($sformatf("mem_en_%0d", j), 65'(o_mem_en), 65'(j < SEQ_LEN));
      if (j < SEQ_LEN) chk($sformatf("mem_addr_%0d", j), 65'(o_mem_addr), 65'(j));
      chk($sformatf("tx_in_%0d", j), 65'(o_tx_in),
          (j >= 2 && j < SEQ_LEN + 2) ? 65'(mem[j - 2][28:0]) : 65'd0);
      chk($sformatf("tx_ref_%0d", j), 65'(o_tx_ref),
          (j >= 2 && j < SEQ_LEN + 2) ? 65'(mem[j - 2][57:29]) : 65'd0);
      chk($sformatf("coll_start_%0d", j), 65'(o_coll_start), 65'(j == 3));
      tick();
    end
    wait_valid("run0_valid");
    chk("run0_value", {o_res_err, o_res_data}, {1'b0, 64'd1024});
    accept("run0");
    chk("run0_one_start", 65'(n_cs - cs0), 65'd1);

    // Timeout: stub silent, result exactly WD_N cycles after coll_start
    stub_en = 1'b0;
    start_run(3, 1);
    repeat (3) tick();
    chk("to_coll_start", 65'(o_coll_start), 65'd1);
    n = 0;
    while (!o_res_valid && n < 300) begin
      tick();
      n++;
    end
    chk("to_latency", 65'(n), 65'(WD_N));
    accept("timeout");
    stub_en = 1'b1;

    // Host stall: result held 20 cycles, cmd_start during HOLD ignored
    cs0 = n_cs;
    start_run(1, 1);
    wait_valid("stall_valid");
    held = {o_res_err, o_res_data};
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_cmd_start = (i == 10);
      tick();
      if ({o_res_err, o_res_data} !== held || !o_res_valid || !o_busy) stable = 1'b0;
    end
    i_cmd_start = 1'b0;
    chk("stall_stable", 65'(stable), 65'd1);
    accept("stall");
    repeat (4) tick();
    chk("stall_cmd_ignored", {62'd0, o_state}, 65'd0);
    chk("stall_one_start", 65'(n_cs - cs0), 65'd1);

    // Reset mid-STREAM at k=4 aborts with no result
    start_run(2, 0);
    repeat (4) tick();
    chk("abort_addr", 65'(o_mem_addr), 65'd4);
    rstn = 1'b0;
    tick();
    chk("abort_outputs", {o_busy, o_mem_en, o_mem_addr, o_tx_in, o_tx_ref, o_coll_start,
                          o_res_valid, o_res_err, o_state},
        65'd0);
    rstn = 1'b1;
    repeat (20) tick();
    chk("abort_no_result", 65'(o_res_valid), 65'd0);
    start_run(2, 1);
    wait_valid("after_abort_valid");
    accept("after_abort");

    // Back-to-back runs with cmd_start pulsed while busy
    cs0 = n_cs;
    for (int r = 0; r < 3; r++) begin
      start_run(1 + (r % 3), 1);
      for (int i = 0; i < 5; i++) begin
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
        tick();
      end
      wait_valid($sformatf("b2b%0d_valid", r));
      accept($sformatf("b2b%0d", r));
    end
    chk("b2b_starts", 65'(n_cs - cs0), 65'd3);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
